// File: rtl/hand_color_counter_pkg.sv
// Shared definitions for the hand colour counter.
//   state_t      : controller states (idle, loading a hand, hand done)
//   COLOR_*      : card colour encoding on card_color
//   calc_pw/cw   : derived widths for the player index and the card counts
package hand_color_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic COLOR_BLACK = 1'b1;
    localparam logic COLOR_WHITE = 1'b0;

    // Player index width; a single-player build still needs one bit
    function automatic int calc_pw(input int num_players);
        int w;
        w = $clog2(num_players);
        return (w < 1) ? 1 : w;
    endfunction

    // Count width, wide enough to hold HAND_SIZE itself
    function automatic int calc_cw(input int hand_size);
        return $clog2(hand_size + 1);
    endfunction

endpackage

// File: rtl/hand_color_counter_if.sv
// Handshake and result-read bundle of the hand colour counter.
//   start/player            : begin a hand for a result slot
//   card_valid/card_color   : card offer, accepted when card_ready is high
//   abort                   : cancel the hand in progress
//   busy/done/err           : status (done is a one-cycle pulse, err sticky)
//   rd_player/rd_black/white: combinational read of a result slot
interface hand_color_counter_if
    import hand_color_counter_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int HAND_SIZE   = 5
);
    localparam int PW = calc_pw(NUM_PLAYERS);
    localparam int CW = calc_cw(HAND_SIZE);

    logic          start;
    logic [PW-1:0] player;
    logic          card_valid;
    logic          card_color;
    logic          card_ready;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic [PW-1:0] rd_player;
    logic [CW-1:0] rd_black;
    logic [CW-1:0] rd_white;

    modport master (
        output start, player, card_valid, card_color, abort, rd_player,
        input  card_ready, busy, done, err, rd_black, rd_white
    );

    modport slave (
        input  start, player, card_valid, card_color, abort, rd_player,
        output card_ready, busy, done, err, rd_black, rd_white
    );

endinterface

// File: rtl/hand_color_counter_color_accum.sv
// Working counters for a single hand.
//   i_clear        : zero all counters (start of a new hand)
//   i_inc/i_color  : count one accepted card of the given colour
//   o_black_next   : black count including this cycle's card
//   o_white_next   : white count including this cycle's card
//   o_last         : the next accepted card completes the hand
module color_accum
    import hand_color_counter_pkg::*;
#(
    parameter  int HAND_SIZE = 5,
    localparam int CW        = calc_cw(HAND_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_inc,
    input  logic          i_color,
    output logic [CW-1:0] o_black_next,
    output logic [CW-1:0] o_white_next,
    output logic          o_last
);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(HAND_SIZE - 1);

    logic [CW-1:0] r_black;
    logic [CW-1:0] r_white;
    logic [CW-1:0] r_index;
    logic          w_inc_black;
    logic          w_inc_white;

    assign w_inc_black  = i_inc && (i_color == COLOR_BLACK);
    assign w_inc_white  = i_inc && (i_color == COLOR_WHITE);
    // Look-ahead values let the owner commit the final card on its own edge
    assign o_black_next = w_inc_black ? (r_black + ONE) : r_black;
    assign o_white_next = w_inc_white ? (r_white + ONE) : r_white;
    assign o_last       = (r_index == LAST_IDX);

    // Counter registers: clear on a new hand, advance on each accepted card
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_black <= {CW{1'b0}};
            r_white <= {CW{1'b0}};
            r_index <= {CW{1'b0}};
        end else if (i_clear) begin
            r_black <= {CW{1'b0}};
            r_white <= {CW{1'b0}};
            r_index <= {CW{1'b0}};
        end else if (i_inc) begin
            r_black <= o_black_next;
            r_white <= o_white_next;
            r_index <= r_index + ONE;
        end else begin
            r_index <= r_index;
        end
    end

endmodule

// File: rtl/hand_color_counter.sv
// Counts black and white cards of a hand and stores the result per player.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of hand_color_counter_if (handshake, status, reads)
module hand_color_counter
    import hand_color_counter_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int HAND_SIZE   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    hand_color_counter_if.slave  bus
);
    localparam int PW = calc_pw(NUM_PLAYERS);
    localparam int CW = calc_cw(HAND_SIZE);
    // One extra bit so the range check also works when NUM_PLAYERS == 2**PW
    localparam logic [PW:0] NP_LIMIT = (PW + 1)'(NUM_PLAYERS);

    state_t        r_state;
    logic [PW-1:0] r_player;
    logic          r_err;
    logic [CW-1:0] r_slot_black [NUM_PLAYERS];
    logic [CW-1:0] r_slot_white [NUM_PLAYERS];

    logic          w_in_load;
    logic          w_accept;
    logic          w_start_ok;
    logic          w_rd_ok;
    logic          w_last;
    logic [CW-1:0] w_black_next;
    logic [CW-1:0] w_white_next;

    assign w_in_load  = (r_state == ST_LOAD);
    // Abort beats a simultaneous card: the card is dropped
    assign w_accept   = w_in_load && bus.card_valid && !bus.abort;
    assign w_start_ok = (r_state == ST_IDLE) && bus.start &&
                        ({1'b0, bus.player} < NP_LIMIT);
    assign w_rd_ok    = ({1'b0, bus.rd_player} < NP_LIMIT);

    color_accum #(
        .HAND_SIZE (HAND_SIZE)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_inc        (w_accept),
        .i_color      (bus.card_color),
        .o_black_next (w_black_next),
        .o_white_next (w_white_next),
        .o_last       (w_last)
    );

    // Controller: hand sequencing, error flag and result-slot commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_player <= {PW{1'b0}};
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_slot_black[i] <= {CW{1'b0}};
                r_slot_white[i] <= {CW{1'b0}};
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_player <= bus.player;
                        r_err    <= 1'b0;
                        r_state  <= ST_LOAD;
                    end else if (bus.start) begin
                        r_err    <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bus.start) begin
                        r_err <= 1'b1;
                    end
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept && w_last) begin
                        r_slot_black[r_player] <= w_black_next;
                        r_slot_white[r_player] <= w_white_next;
                        r_state                <= ST_DONE;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        r_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.card_ready = w_in_load;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = r_err;
    assign bus.rd_black   = w_rd_ok ? r_slot_black[bus.rd_player] : {CW{1'b0}};
    assign bus.rd_white   = w_rd_ok ? r_slot_white[bus.rd_player] : {CW{1'b0}};

endmodule

// File: tb/tb_hand_color_counter.sv
// Self-checking bench for hand_color_counter (NUM_PLAYERS=2, HAND_SIZE=5),
// plus a 3-player instance used for out-of-range player handling.
module tb_hand_color_counter;
    import hand_color_counter_pkg::*;

    localparam int NP = 2;
    localparam int HS = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hand_color_counter_if #(.NUM_PLAYERS(NP), .HAND_SIZE(HS)) bus ();
    hand_color_counter #(.NUM_PLAYERS(NP), .HAND_SIZE(HS)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    hand_color_counter_if #(.NUM_PLAYERS(3), .HAND_SIZE(HS)) bus3 ();
    hand_color_counter #(.NUM_PLAYERS(3), .HAND_SIZE(HS)) u_dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase 0 = waiting, 1 = collecting cards, 2 = hand just finished
    int m_phase;
    bit m_q[$];
    int m_player;
    bit m_err;
    int m_b [NP];
    int m_w [NP];

    typedef struct {
        logic s; int p; logic v; logic c; logic a;
        logic e_rdy; logic e_busy; logic e_done; logic e_err;
        int e_b0; int e_w0;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase  = 0;
        m_q.delete();
        m_player = 0;
        m_err    = 1'b0;
        for (int i = 0; i < NP; i++) begin
            m_b[i] = 0;
            m_w[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic s, input int p, input logic v,
                                       input logic c, input logic a);
        int nb;
        if (m_phase == 0) begin
            if (s) begin
                if (p < NP) begin
                    m_player = p;
                    m_q.delete();
                    m_err   = 1'b0;
                    m_phase = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            if (s) m_err = 1'b1;
            if (a) begin
                m_phase = 0;
            end else if (v) begin
                m_q.push_back(c);
                if (m_q.size() == HS) begin
                    nb = 0;
                    foreach (m_q[i]) nb += int'(m_q[i]);
                    m_b[m_player] = nb;
                    m_w[m_player] = HS - nb;
                    m_phase = 2;
                end
            end
        end else begin
            if (s) m_err = 1'b1;
            m_phase = 0;
        end
    endfunction

    task automatic compare_all();
        chk("card_ready", 32'(bus.card_ready), 32'(m_phase == 1));
        chk("busy",       32'(bus.busy),       32'(m_phase != 0));
        chk("done",       32'(bus.done),       32'(m_phase == 2));
        chk("err",        32'(bus.err),        32'(m_err));
        for (int s = 0; s < NP; s++) begin
            bus.rd_player = 1'(s);
            #1;
            chk("rd_black", 32'(bus.rd_black), 32'(m_b[s]));
            chk("rd_white", 32'(bus.rd_white), 32'(m_w[s]));
        end
        bus.rd_player = 1'b0;
        #1;
    endtask

    task automatic cyc(input logic s, input int p, input logic v, input logic c, input logic a);
        bus.start      = s;
        bus.player     = 1'(p);
        bus.card_valid = v;
        bus.card_color = c;
        bus.abort      = a;
        model_step(s, p, v, c, a);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Hand for player 0: colours 1,0,1,0,1 back-to-back
        tbl[0] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[4] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[5] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 2};
        tbl[6] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2};

        bus.start = 1'b0; bus.player = 1'b0; bus.card_valid = 1'b0;
        bus.card_color = 1'b0; bus.abort = 1'b0; bus.rd_player = 1'b0;
        bus3.start = 1'b0; bus3.player = 2'd0; bus3.card_valid = 1'b0;
        bus3.card_color = 1'b0; bus3.abort = 1'b0; bus3.rd_player = 2'd0;

        // Reset state
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        idle();

        // Table-driven first hand
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].c, tbl[i].a);
            chk("tbl_ready", 32'(bus.card_ready), 32'(tbl[i].e_rdy));
            chk("tbl_busy",  32'(bus.busy),       32'(tbl[i].e_busy));
            chk("tbl_done",  32'(bus.done),       32'(tbl[i].e_done));
            chk("tbl_err",   32'(bus.err),        32'(tbl[i].e_err));
            chk("tbl_black0", 32'(bus.rd_black),  32'(tbl[i].e_b0));
            chk("tbl_white0", 32'(bus.rd_white),  32'(tbl[i].e_w0));
        end

        // Player 1: five black cards with valid gaps
        cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
                cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
            end
            cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        end
        chk("gap_done", 32'(bus.done), 32'd1);
        idle();
        bus.rd_player = 1'b1; #1;
        chk("gap_black1", 32'(bus.rd_black), 32'd5);
        chk("gap_white1", 32'(bus.rd_white), 32'd0);
        bus.rd_player = 1'b0; #1;
        chk("gap_black0", 32'(bus.rd_black), 32'd3);
        chk("gap_white0", 32'(bus.rd_white), 32'd2);

        // Abort coinciding with a card handshake
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        idle();
        chk("abort_done2", 32'(bus.done), 32'd0);
        chk("abort_black0", 32'(bus.rd_black), 32'd3);
        chk("abort_white0", 32'(bus.rd_white), 32'd2);

        // Start during LOAD and during DONE set err; hand still completes
        cyc(1'b1, 1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 0, 1'b1, 1'b0, 1'b0);
        chk("load_start_err", 32'(bus.err), 32'd1);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("err_hand_done", 32'(bus.done), 32'd1);
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("done_start_err", 32'(bus.err), 32'd1);
        chk("done_start_busy", 32'(bus.busy), 32'd0);
        bus.rd_player = 1'b1; #1;
        chk("err_black1", 32'(bus.rd_black), 32'd3);
        chk("err_white1", 32'(bus.rd_white), 32'd2);
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        chk("err_cleared", 32'(bus.err), 32'd0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Out-of-range player and read on a 3-player instance
        bus3.start = 1'b1; bus3.player = 2'd3;
        @(posedge clk); #1;
        chk("oor_err", 32'(bus3.err), 32'd1);
        chk("oor_busy", 32'(bus3.busy), 32'd0);
        bus3.start = 1'b0; bus3.rd_player = 2'd3; #1;
        chk("oor_rd_black", 32'(bus3.rd_black), 32'd0);
        chk("oor_rd_white", 32'(bus3.rd_white), 32'd0);
        bus3.start = 1'b1; bus3.player = 2'd2;
        @(posedge clk); #1;
        chk("p2_err", 32'(bus3.err), 32'd0);
        chk("p2_busy", 32'(bus3.busy), 32'd1);
        bus3.start = 1'b0; bus3.abort = 1'b1;
        @(posedge clk); #1;
        chk("p2_abort_busy", 32'(bus3.busy), 32'd0);
        bus3.abort = 1'b0;

        // Reset in the middle of a hand
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_black0", 32'(bus.rd_black), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        chk("midrst_done2", 32'(bus.done), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                cyc(1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 19) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
